enemy_collision_detect: RTL and testbench
=========================================

ENEMY_COLLISION_DETECT -- requirements
Module: enemy_collision_detect

Interface
REQ-001 Parameters (name, default, meaning) SHALL be one per line:
- ENEMY_W, 16, enemy sprite width in pixels
- ENEMY_H, 16, enemy sprite height in pixels
- SPACING_X, 24, column pitch in pixels
- SPACING_Y, 20, row pitch in pixels
REQ-002 Ports (name, direction, width, meaning) SHALL be one per line:
- clk, in, 1, system clock
- reset, in, 1, reset, asynchronous, active-high
- frame_start, in, 1, one-cycle pulse per video frame
- missile_active, in, 1, player missile in flight
- missile_x, in, 10, missile tip x pixel
- missile_y, in, 10, missile tip y pixel
- grid_x, in, 10, formation top-left x
- grid_y, in, 10, formation top-left y
- enemy_status, in, [9:0][5:0], alive bit per column/row
- enemy_hit, out, 7, {col[3:0], row[2:0]} of last hit enemy
- collision, out, 1, hit strobe to the enemy-status stage
- missile_kill, out, 1, one-cycle pulse to retire the missile
- hits_count, out, 6, enemies destroyed since reset
- all_dead, out, 1, high when hits_count == 60

Function
REQ-003 FSM states SHALL be IDLE, CAPTURE, DIVIDE, CHECK, HIT, STROBE, DONE; all outputs SHALL be registered.
REQ-004 In IDLE, frame_start=1 with missile_active=1 SHALL go to CAPTURE; otherwise stay in IDLE. frame_start in any other state SHALL be ignored.
REQ-005 CAPTURE SHALL latch dx = missile_x - grid_x and dy = missile_y - grid_y as 11-bit signed values, then go to DIVIDE.
- Positions SHALL be used only as latched; missile_active SHALL have no effect after CAPTURE.
REQ-006 If dx or dy is negative on entry to DIVIDE, the FSM SHALL go to DONE with no hit.
REQ-007 DIVIDE SHALL compute col and row by repeated subtraction, col and row in parallel, one step per cycle:
- while rem_x >= SPACING_X: rem_x -= SPACING_X, col += 1
- while rem_y >= SPACING_Y: rem_y -= SPACING_Y, row += 1
- DIVIDE SHALL complete in at most 11 cycles.
REQ-008 If col would exceed 9 or row would exceed 5, DIVIDE SHALL abort immediately to DONE with no hit.
REQ-009 CHECK SHALL go to HIT iff rem_x < ENEMY_W, rem_y < ENEMY_H and enemy_status[col][row]=1; otherwise it SHALL go to DONE.
REQ-010 On HIT entry, enemy_hit SHALL load {col, row}, and hits_count SHALL increment, saturating at 60.
- In that same cycle, missile_kill SHALL pulse for exactly one cycle.
REQ-011 collision SHALL rise in the cycle after enemy_hit loads and stay high for exactly 2 cycles (HIT, then STROBE).
- enemy_hit SHALL be stable at least 1 cycle before, during, and after collision is high.
REQ-012 enemy_hit SHALL hold its value until the next hit; DONE SHALL return to IDLE after 1 cycle.
REQ-013 At most one hit SHALL be reported per frame_start.
- Latency from frame_start to collision rise SHALL be at most 15 cycles.
REQ-014 all_dead SHALL equal (hits_count == 60), registered, and SHALL stay high until reset.

Reset
REQ-015 Asserting reset SHALL asynchronously force the state to IDLE and clear all outputs.
- Cleared outputs: enemy_hit=0, collision=0, missile_kill=0, hits_count=0, all_dead=0.
- Cleared internals: col, row, remainders.
REQ-016 Reset mid-operation SHALL abort any check; no collision or missile_kill pulse SHALL appear after reset deasserts.
- The first frame_start after deassertion SHALL be processed normally.

Verification
REQ-017 Column 3, row 2 hit: grid=(100,50), missile=(177,94), all alive, frame_start pulse.
- Required: enemy_hit=7'b0011010; collision high 2 cycles; missile_kill 1 cycle; hits_count=1.
REQ-018 Gap miss: grid=(100,50), missile=(190,94) gives rem_x=18.
- Required: no collision, no missile_kill, hits_count unchanged.
REQ-019 Dead target: repeat REQ-017 with enemy_status[3][2]=0.
- Required: no collision; enemy_hit keeps its previous value.
REQ-020 Out of range:
- missile_x=99 (dx<0) SHALL give no hit.
- missile_x=100+240 (col=10) SHALL give no hit.
- A second frame_start during DIVIDE SHALL be ignored.
REQ-021 Reset mid-operation: assert reset during DIVIDE of a REQ-017 stimulus.
- Required: all outputs 0 immediately; no collision after release; next frame_start hits normally.
REQ-022 Full clear: hit all 60 positions, one per frame.
- Required: hits_count=60 and all_dead=1; a further frame_start with a dead target keeps hits_count=60.

Source files
------------

// File: rtl/enemy_collision_detect.sv
// rtl/enemy_collision_detect.sv - missile vs. enemy formation hit test, one check per video frame
// Column/row found by serial subtraction so no divider is needed; all outputs registered.
module enemy_collision_detect #(
   parameter int ENEMY_W   = 16,
   parameter int ENEMY_H   = 16,
   parameter int SPACING_X = 24,
   parameter int SPACING_Y = 20
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            frame_start,
   input  logic            missile_active,
   input  logic [9:0]      missile_x,
   input  logic [9:0]      missile_y,
   input  logic [9:0]      grid_x,
   input  logic [9:0]      grid_y,
   input  logic [9:0][5:0] enemy_status,
   output logic [6:0]      enemy_hit,
   output logic            collision,
   output logic            missile_kill,
   output logic [5:0]      hits_count,
   output logic            all_dead
);

   typedef enum logic [2:0] {IDLE, CAPTURE, DIVIDE, CHECK, HIT, STROBE, DONE} state_t;

   localparam logic [10:0] SX = 11'(SPACING_X);
   localparam logic [10:0] SY = 11'(SPACING_Y);
   localparam logic [10:0] EW = 11'(ENEMY_W);
   localparam logic [10:0] EH = 11'(ENEMY_H);

   state_t      state, state_next;
   logic [10:0] rem_x, rem_y;
   logic [3:0]  col;
   logic [2:0]  row;
   logic        step_x, step_y;

   assign step_x = (rem_x >= SX);
   assign step_y = (rem_y >= SY);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (frame_start && missile_active) state_next = CAPTURE;
         CAPTURE: state_next = DIVIDE;
         DIVIDE: begin
            // bit 10 is the sign of the latched offset: missile left of / above the grid
            if (rem_x[10] || rem_y[10])
               state_next = DONE;
            else if ((step_x && col == 4'd9) || (step_y && row == 3'd5))
               state_next = DONE;
            else if (!step_x && !step_y)
               state_next = CHECK;
         end
         CHECK: begin
            if (rem_x < EW && rem_y < EH && enemy_status[col][row])
               state_next = HIT;
            else
               state_next = DONE;
         end
         HIT:     state_next = STROBE;
         STROBE:  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         rem_x        <= '0;
         rem_y        <= '0;
         col          <= '0;
         row          <= '0;
         enemy_hit    <= '0;
         collision    <= 1'b0;
         missile_kill <= 1'b0;
         hits_count   <= '0;
         all_dead     <= 1'b0;
      end else begin
         state        <= state_next;
         missile_kill <= 1'b0;
         // collision trails enemy_hit by one cycle so the status stage sees a settled address
         collision    <= (state == HIT) || (state == STROBE);
         all_dead     <= all_dead || (hits_count == 6'd60);

         if (state == CAPTURE) begin
            rem_x <= {1'b0, missile_x} - {1'b0, grid_x};
            rem_y <= {1'b0, missile_y} - {1'b0, grid_y};
            col   <= '0;
            row   <= '0;
         end

         if (state == DIVIDE && state_next == DIVIDE) begin
            if (step_x) begin
               rem_x <= rem_x - SX;
               col   <= col + 4'd1;
            end
            if (step_y) begin
               rem_y <= rem_y - SY;
               row   <= row + 3'd1;
            end
         end

         if (state == CHECK && state_next == HIT) begin
            enemy_hit    <= {col, row};
            missile_kill <= 1'b1;
            if (hits_count != 6'd60)
               hits_count <= hits_count + 6'd1;
         end
      end
   end

endmodule

// File: tb/tb_enemy_collision_detect.sv
// tb/tb_enemy_collision_detect.sv - directed and randomized frames against an arithmetic hit model
module tb_enemy_collision_detect;

   localparam int EW = 16;
   localparam int EH = 16;
   localparam int SX = 24;
   localparam int SY = 20;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            frame_start = 1'b0;
   logic            missile_active = 1'b0;
   logic [9:0]      missile_x = '0, missile_y = '0, grid_x = '0, grid_y = '0;
   logic [9:0][5:0] enemy_status = '1;
   logic [6:0]      enemy_hit;
   logic            collision, missile_kill, all_dead;
   logic [5:0]      hits_count;

   int vectors = 0;
   int miscompares = 0;
   int exp_hits = 0;
   logic [6:0] exp_eh = '0;

   enemy_collision_detect #(
      .ENEMY_W(EW), .ENEMY_H(EH), .SPACING_X(SX), .SPACING_Y(SY)
   ) dut (
      .clk(clk), .reset(reset), .frame_start(frame_start), .missile_active(missile_active),
      .missile_x(missile_x), .missile_y(missile_y), .grid_x(grid_x), .grid_y(grid_y),
      .enemy_status(enemy_status), .enemy_hit(enemy_hit), .collision(collision),
      .missile_kill(missile_kill), .hits_count(hits_count), .all_dead(all_dead)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Geometry by plain division: which cell does the tip fall into, and is it inside the sprite?
   function automatic void model(input int mx, input int my, input int gx, input int gy,
                                 input logic [9:0][5:0] st, output bit hit, output logic [6:0] id);
      int dx, dy, c, r;
      dx = mx - gx;
      dy = my - gy;
      hit = 1'b0;
      id = '0;
      if (dx >= 0 && dy >= 0) begin
         c = dx / SX;
         r = dy / SY;
         if (c <= 9 && r <= 5 && (dx % SX) < EW && (dy % SY) < EH && st[c][r]) begin
            hit = 1'b1;
            id = {c[3:0], r[2:0]};
         end
      end
   endfunction

   task automatic run_frame(input int mx, input int my, input int gx, input int gy,
                            input bit active, input bit extra, input string tag);
      bit hit;
      logic [6:0] id;
      int ncol, nkill, first, killat;
      logic [6:0] eh_hist[0:31];
      model(mx, my, gx, gy, enemy_status, hit, id);
      if (!active) hit = 1'b0;
      @(negedge clk);
      missile_x = 10'(mx);
      missile_y = 10'(my);
      grid_x = 10'(gx);
      grid_y = 10'(gy);
      missile_active = active;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      ncol = 0; nkill = 0; first = -1; killat = -1;
      for (int k = 1; k <= 28; k++) begin
         @(negedge clk);
         frame_start = (extra && k == 3);
         eh_hist[k] = enemy_hit;
         if (collision) begin
            ncol++;
            if (first < 0) first = k;
         end
         if (missile_kill) begin
            nkill++;
            if (killat < 0) killat = k;
         end
      end
      frame_start = 1'b0;
      if (hit) begin
         exp_eh = id;
         if (exp_hits < 60) exp_hits++;
      end
      check({tag, ":collision_cycles"}, ncol, hit ? 2 : 0);
      check({tag, ":kill_cycles"}, nkill, hit ? 1 : 0);
      check({tag, ":enemy_hit"}, enemy_hit, exp_eh);
      check({tag, ":hits_count"}, hits_count, exp_hits);
      check({tag, ":all_dead"}, all_dead, exp_hits == 60);
      if (hit && first >= 2 && first <= 26) begin
         check({tag, ":latency_ok"}, first <= 15, 1);
         check({tag, ":kill_before_collision"}, killat, first - 1);
         check({tag, ":eh_before"}, eh_hist[first - 1], id);
         check({tag, ":eh_after"}, eh_hist[first + 2], id);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_hits = 0;
      exp_eh = '0;
   endtask

   initial begin
      int ncol, nkill, gx, gy, mx, my;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset:enemy_hit", enemy_hit, 0);
      check("reset:collision", collision, 0);
      check("reset:missile_kill", missile_kill, 0);
      check("reset:hits_count", hits_count, 0);
      check("reset:all_dead", all_dead, 0);

      enemy_status = '1;
      run_frame(177, 94, 100, 50, 1'b1, 1'b0, "col3_row2");
      check("col3_row2:code", enemy_hit, 7'b0011010);
      run_frame(190, 94, 100, 50, 1'b1, 1'b0, "gap_miss");
      enemy_status[3][2] = 1'b0;
      run_frame(177, 94, 100, 50, 1'b1, 1'b0, "dead_target");
      enemy_status = '1;
      run_frame(99, 94, 100, 50, 1'b1, 1'b0, "dx_negative");
      run_frame(340, 94, 100, 50, 1'b1, 1'b0, "col10");
      run_frame(100 + 8 * SX + 3, 50 + 4 * SY + 2, 100, 50, 1'b1, 1'b1, "extra_frame_start");
      run_frame(130, 60, 100, 50, 1'b0, 1'b0, "missile_inactive");

      for (int i = 0; i < 30; i++) begin
         gx = $urandom_range(10, 600);
         gy = $urandom_range(10, 600);
         mx = gx + $urandom_range(0, 260) - 8;
         my = gy + $urandom_range(0, 130) - 6;
         enemy_status = 60'({$urandom(), $urandom()});
         run_frame(mx, my, gx, gy, 1'b1, 1'b0, "random");
      end

      enemy_status = '1;
      run_frame(177, 94, 100, 50, 1'b1, 1'b0, "pre_reset_hit");
      @(negedge clk);
      frame_start = 1'b1;
      missile_active = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midreset:enemy_hit", enemy_hit, 0);
      check("midreset:collision", collision, 0);
      check("midreset:missile_kill", missile_kill, 0);
      check("midreset:hits_count", hits_count, 0);
      check("midreset:all_dead", all_dead, 0);
      @(negedge clk);
      reset = 1'b0;
      exp_hits = 0;
      exp_eh = '0;
      ncol = 0;
      nkill = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (collision) ncol++;
         if (missile_kill) nkill++;
      end
      check("midreset:no_collision_after", ncol, 0);
      check("midreset:no_kill_after", nkill, 0);
      run_frame(177, 94, 100, 50, 1'b1, 1'b0, "post_reset_hit");

      do_reset();
      enemy_status = '1;
      for (int c = 0; c < 10; c++) begin
         for (int r = 0; r < 6; r++) begin
            gx = $urandom_range(0, 700);
            gy = $urandom_range(0, 800);
            mx = gx + c * SX + $urandom_range(0, EW - 1);
            my = gy + r * SY + $urandom_range(0, EH - 1);
            run_frame(mx, my, gx, gy, 1'b1, 1'b0, "full_clear");
            enemy_status[c][r] = 1'b0;
         end
      end
      check("full_clear:hits_60", hits_count, 60);
      check("full_clear:all_dead", all_dead, 1);
      run_frame(177, 94, 100, 50, 1'b1, 1'b0, "after_clear_dead");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
